// File: rtl/snespad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snespad_pkg
// Brief    : Shared constants and FSM encoding for the SNES pad serial device.
// Revision : 1.0 - initial release
// ============================================================================
package snespad_pkg;

    localparam int c_reg_size = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } snes_state_t;

    // Bit positions in buttons_i; B sits at the MSB so it is the first bit out.
    localparam int c_btn_b      = 15;
    localparam int c_btn_y      = 14;
    localparam int c_btn_select = 13;
    localparam int c_btn_start  = 12;
    localparam int c_btn_up     = 11;
    localparam int c_btn_down   = 10;
    localparam int c_btn_left   = 9;
    localparam int c_btn_right  = 8;
    localparam int c_btn_a      = 7;
    localparam int c_btn_x      = 6;
    localparam int c_btn_l      = 5;
    localparam int c_btn_r      = 4;

endpackage
`default_nettype wire

// File: rtl/snespad_device_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Two-flop synchronizer for a single asynchronous level, resets to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule
`default_nettype wire

// File: rtl/snespad_device.sv
`default_nettype none
// ============================================================================
// Module   : snespad_device
// Brief    : SNES controller emulation; shifts a button word out to a console.
// Revision : 1.0 - initial release
// ============================================================================
module snespad_device
    import snespad_pkg::*;
#(
    parameter int   REG_SIZE = c_reg_size,
    parameter logic FILL_BIT = 1'b1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                dlatch_i,
    input  logic                dclock_i,
    input  logic [REG_SIZE-1:0] buttons_i,
    output logic                sdata_o,
    output logic                busy_o,
    output logic                frame_o,
    output logic                ovf_o
);

    localparam int               c_cnt_w      = $clog2(REG_SIZE) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    // The first bit leaves during latch, so REG_SIZE-1 shifts finish a frame.
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(REG_SIZE - 2);
    localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(REG_SIZE);

    logic w_latch_s;
    logic w_dclk_s;

    sync2 u_sync_latch (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (dlatch_i),
        .q_o    (w_latch_s)
    );

    sync2 u_sync_dclk (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (dclock_i),
        .q_o    (w_dclk_s)
    );

    // Registered edge pulses; the level copies stay aligned with the pulses.
    logic r_latch_lvl;
    logic r_latch_rise;
    logic r_latch_fall;
    logic r_dclk_lvl;
    logic r_dclk_rise;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_latch_lvl  <= 1'b0;
            r_latch_rise <= 1'b0;
            r_latch_fall <= 1'b0;
            r_dclk_lvl   <= 1'b0;
            r_dclk_rise  <= 1'b0;
        end else begin
            r_latch_lvl  <= w_latch_s;
            r_latch_rise <= w_latch_s & ~r_latch_lvl;
            r_latch_fall <= ~w_latch_s & r_latch_lvl;
            r_dclk_lvl   <= w_dclk_s;
            r_dclk_rise  <= w_dclk_s & ~r_dclk_lvl;
        end
    end

    snes_state_t          r_state;
    logic [REG_SIZE-1:0]  r_shreg;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_sdata;
    logic                 r_busy;
    logic                 r_frame;
    logic                 r_ovf;

    logic w_do_load;
    logic w_step;

    always_comb begin
        w_do_load = 1'b0;
        if (r_latch_rise) begin
            w_do_load = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: w_do_load = r_latch_lvl;
                ST_LOAD: w_do_load = ~r_latch_fall;
                default: w_do_load = 1'b0;
            endcase
        end
    end

    // A latch edge coinciding with a data clock edge swallows the clock edge.
    assign w_step = r_dclk_rise & ~r_latch_fall;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_shreg <= {REG_SIZE{FILL_BIT}};
            r_count <= '0;
            r_sdata <= FILL_BIT;
            r_busy  <= 1'b0;
            r_frame <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            if (w_do_load) begin
                r_state <= ST_LOAD;
                r_shreg <= buttons_i;
                r_sdata <= buttons_i[REG_SIZE-1];
                r_count <= '0;
                r_busy  <= 1'b0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                    ST_SHIFT: begin
                        if (w_step) begin
                            r_shreg <= {r_shreg[REG_SIZE-2:0], FILL_BIT};
                            r_sdata <= r_shreg[REG_SIZE-2];
                            r_count <= r_count + c_cnt_one;
                            if (r_count == c_last_cnt) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_frame <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (r_latch_fall) begin
                            r_state <= ST_IDLE;
                        end else if (w_step) begin
                            r_shreg <= {r_shreg[REG_SIZE-2:0], FILL_BIT};
                            r_sdata <= FILL_BIT;
                            r_ovf   <= 1'b1;
                            if (r_count != c_cnt_sat) begin
                                r_count <= r_count + c_cnt_one;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sdata_o = r_sdata;
    assign busy_o  = r_busy;
    assign frame_o = r_frame;
    assign ovf_o   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_snespad_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_snespad_device
// Brief    : Self-checking bench; a console/reader model sampling sdata_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snespad_device;

    localparam int   REG_SIZE = 16;
    localparam logic FILL_BIT = 1'b1;

    logic                clk_i     = 1'b0;
    logic                rstn_i    = 1'b0;
    logic                dlatch_i  = 1'b0;
    logic                dclock_i  = 1'b0;
    logic [REG_SIZE-1:0] buttons_i = '0;
    logic                sdata_o;
    logic                busy_o;
    logic                frame_o;
    logic                ovf_o;

    int n_vec     = 0;
    int n_err     = 0;
    int frame_cnt = 0;

    always #5 clk_i = ~clk_i;

    snespad_device #(
        .REG_SIZE (REG_SIZE),
        .FILL_BIT (FILL_BIT)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .dlatch_i  (dlatch_i),
        .dclock_i  (dclock_i),
        .buttons_i (buttons_i),
        .sdata_o   (sdata_o),
        .busy_o    (busy_o),
        .frame_o   (frame_o),
        .ovf_o     (ovf_o)
    );

    always @(negedge clk_i) begin
        if (frame_o) frame_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Console side: latch, then nshifts data clock pulses; the reader samples
    // each bit just before ending the latch / each data clock high phase.
    task automatic run_frame(input logic [15:0] btn, input logic [15:0] btn_after,
                             input int nshifts, input int hp, output logic [15:0] word);
        logic exp_bit;
        word      = '0;
        buttons_i = btn;
        dlatch_i  = 1'b1;
        wait_cyc(hp);
        check_value("ovf_clr", ovf_o, 0);
        check_value("bit0", sdata_o, btn[15]);
        word[15]  = sdata_o;
        dlatch_i  = 1'b0;
        wait_cyc(3);
        buttons_i = btn_after;
        wait_cyc(hp - 3);
        for (int i = 1; i <= nshifts; i++) begin
            dclock_i = 1'b1;
            wait_cyc(hp);
            exp_bit = (i < REG_SIZE) ? btn[REG_SIZE-1-i] : FILL_BIT;
            check_value($sformatf("bit%0d", i), sdata_o, exp_bit);
            if (i < REG_SIZE) word[REG_SIZE-1-i] = sdata_o;
            if (i == 5) check_value("busy_mid", busy_o, 1);
            dclock_i = 1'b0;
            wait_cyc(hp);
        end
    endtask

    task automatic frame_case(input string name, input logic [15:0] btn, input logic [15:0] btn_after,
                              input int nshifts, input int hp);
        int          f0;
        logic [15:0] word;
        f0 = frame_cnt;
        run_frame(btn, btn_after, nshifts, hp, word);
        check_value({name, "_frames"}, frame_cnt - f0, (nshifts >= REG_SIZE - 1) ? 1 : 0);
        check_value({name, "_ovf"}, ovf_o, (nshifts > REG_SIZE - 1) ? 1 : 0);
        check_value({name, "_busy"}, busy_o, (nshifts < REG_SIZE - 1) ? 1 : 0);
        if (nshifts >= REG_SIZE - 1) check_value({name, "_word"}, word, btn);
    endtask

    initial begin
        int          f0;
        int          ns;
        logic [15:0] word;

        wait_cyc(3);
        check_value("rst_sdata", sdata_o, FILL_BIT);
        check_value("rst_busy", busy_o, 0);
        check_value("rst_frame", frame_o, 0);
        check_value("rst_ovf", ovf_o, 0);
        rstn_i = 1'b1;
        wait_cyc(3);

        frame_case("a5c3", 16'hA5C3, 16'($urandom), 15, 6);
        frame_case("loop", 16'h0F0F, 16'($urandom), 15, 8);

        // Abort after 6 shifts, then a full frame with a different word.
        frame_case("abort", 16'h3C96, 16'($urandom), 6, 6);
        frame_case("after_abort", 16'hC35A, 16'($urandom), 15, 7);

        // Three extra clocks past the frame end, then the next latch clears ovf.
        frame_case("ovf", 16'h1234, 16'($urandom), 18, 6);
        frame_case("after_ovf", 16'hFEDC, 16'($urandom), 15, 6);

        // Buttons flip right after the latch falls; the frame keeps the old word.
        frame_case("late_btn", 16'h0000, 16'hFFFF, 15, 6);

        // Asynchronous reset in the middle of shifting.
        f0 = frame_cnt;
        run_frame(16'h8001, 16'h8001, 5, 6, word);
        #3 rstn_i = 1'b0;
        #1;
        check_value("arst_sdata", sdata_o, FILL_BIT);
        check_value("arst_busy", busy_o, 0);
        check_value("arst_ovf", ovf_o, 0);
        check_value("arst_frames", frame_cnt - f0, 0);
        wait_cyc(2);
        rstn_i = 1'b1;
        wait_cyc(2);
        frame_case("after_arst", 16'h5AA5, 16'($urandom), 15, 6);

        // Reset released while the latch is already high.
        rstn_i   = 1'b0;
        dlatch_i = 1'b1;
        wait_cyc(3);
        rstn_i   = 1'b1;
        frame_case("rst_latch", 16'h6E1B, 16'($urandom), 15, 6);

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 3) == 0) ns = int'($urandom_range(1, 14));
            else                           ns = int'($urandom_range(15, 17));
            frame_case($sformatf("rnd%0d", k), 16'($urandom), 16'($urandom), ns,
                       int'($urandom_range(6, 10)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snespad_device.md
SNESPAD_DEVICE -- requirements
Module: snespad_device

Interface
REQ-001 Parameter: REG_SIZE, 16, number of bits shifted per frame.
REQ-002 Parameter: FILL_BIT, 1'b1, value driven on sdata_o after all REG_SIZE bits are shifted.
REQ-003 Port: clk_i  input  1  system clock; one clock domain only.
REQ-004 Port: rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: dlatch_i  input  1  latch from console/reader; asynchronous to clk_i.
REQ-006 Port: dclock_i  input  1  data clock from console/reader; asynchronous to clk_i.
REQ-007 Port: sdata_o  output  1  serial button data to reader; registered.
REQ-008 Port: buttons_i  input  REG_SIZE  button word; bit REG_SIZE-1 is sent first.
REQ-009 Port: busy_o  output  1  high while a frame is being shifted (SHIFT state).
REQ-010 Port: frame_o  output  1  one-cycle pulse when the REG_SIZE-th bit has been shifted out.
REQ-011 Port: ovf_o  output  1  sticky: dclock rising edge seen after frame end; cleared on next latch.

Function
REQ-012 dlatch_i and dclock_i SHALL each pass through a 2-flop synchronizer, then a 1-flop edge detector (rise/fall pulses).
REQ-013 FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE: synchronized latch high -> LOAD; dclock edges ignored.
REQ-015 LOAD: shift register reloaded from buttons_i every cycle; sdata_o follows buttons_i[REG_SIZE-1] one cycle later; bit counter cleared; ovf_o cleared.
REQ-016 LOAD -> SHIFT on synchronized latch falling edge; register holds last value loaded while latch was high.
REQ-017 SHIFT: each synchronized dclock rising edge shifts register left by one, inserting FILL_BIT at LSB, and increments counter; sdata_o updates the following cycle.
REQ-018 SHIFT -> DONE on the rising edge that brings counter to REG_SIZE-1 (i.e. REG_SIZE-1 shifts; first bit was presented during latch); frame_o pulses that cycle.
REQ-019 DONE: sdata_o = FILL_BIT; any further dclock rising edge sets ovf_o; DONE -> IDLE when latch low, DONE -> LOAD on latch rise.
REQ-020 Latch rise in any state (including mid-SHIFT) SHALL abort and enter LOAD; no frame_o for an aborted frame.
REQ-021 Latch edge and dclock rise in same cycle: latch wins; dclock edge discarded.
REQ-022 dclock falling edges SHALL have no effect.
REQ-023 Latency: pin edge to sdata_o change = 4 clk_i cycles (2 sync + 1 edge + 1 output reg); total ≤ 4 cycles required.
REQ-024 Counter width = $clog2(REG_SIZE)+1; SHALL never wrap; saturates in DONE.

Reset
REQ-025 While rstn_i low: state IDLE, shift register all FILL_BIT, counter 0, synchronizer flops 0, sdata_o = FILL_BIT, busy_o = 0, frame_o = 0, ovf_o = 0.
REQ-026 Reset deassertion mid-latch SHALL resolve through sync chain: IDLE then LOAD after synchronizer delay; no spurious frame_o.

Structure
REQ-027 Package snespad_pkg SHALL hold REG_SIZE default, FSM state encoding constants, and button-bit index constants (B, Y, SELECT, START, UP, DOWN, LEFT, RIGHT, A, X, L, R).
REQ-028 Sub-module sync2 (2-flop synchronizer, async active-low reset to 0) instantiated twice.
REQ-029 Design SHALL be compatible with the existing SNes pad reader: reader sample during latch gets bit REG_SIZE-1, its 15 dclock-high samples get the remaining bits MSB first.

Verification
REQ-030 buttons_i=16'hA5C3, latch 12 us, 15 dclock pulses (12 us period) -> sdata_o sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; frame_o one pulse; ovf_o=0.
REQ-031 Loopback with SNes pad reader model, buttons_i=16'h0F0F -> reader vdata_o = 16'h0F0F.
REQ-032 Latch reasserted after 6 shifts -> sdata_o returns to buttons_i MSB; no frame_o; next full frame correct.
REQ-033 Full frame then 3 extra dclock pulses -> sdata_o=1 constant, ovf_o=1; next latch clears ovf_o=0.
REQ-034 buttons_i changed 16'h0000->16'hFFFF one cycle after synchronized latch fall -> shifted frame all 0s.
REQ-035 rstn_i pulsed low mid-SHIFT -> sdata_o=1, busy_o=0 immediately (async); next latch/frame correct.
